mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter and sequencer that shares one 256-bit Karatsuba field multiplier (mod p = 2^255−19, optional reduction) between N_REQ requesters in the EdDSA datapath, e.g. point-add, point-double and inversion units. It grants one requester at a time and registers its operands and reduction mode. It drives the multiplier's restart line, waits for the multiplier's valid, then returns the registered product with a one-cycle done pulse to the winning requester.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BIT_LENGTH, 256, operand width
- TIMEOUT_CYCLES, 64, watchdog limit in RUN (used only with MULT_ARB_TIMEOUT_EN)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level
- req_redux  in  N_REQ  per-requester reduction select (1 = mod p, 0 = full product)
- req_a  in  N_REQ*BIT_LENGTH  operand A, requester i at slice [i*BIT_LENGTH +: BIT_LENGTH]
- req_b  in  N_REQ*BIT_LENGTH  operand B, same packing
- gnt  out  N_REQ  one-hot grant pulse
- done  out  N_REQ  one-hot completion pulse
- err  out  1  completion flag, qualifies done: 1 = watchdog abort
- result  out  2*BIT_LENGTH  registered product, valid while done is high and held afterwards
- busy  out  1  high in every state except IDLE
- mult_rst  out  1  multiplier reset, active-high
- mult_redux  out  1  multiplier reduction select
- mult_a, mult_b  out  BIT_LENGTH  multiplier operands (registered)
- mult_u  in  2*BIT_LENGTH  multiplier product
- mult_valid  in  1  multiplier output valid

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - mult_rst=1.
  - If any req bit is set, select the first set bit at or after rr_ptr (wrapping).
  - Pulse gnt for that requester.
  - Capture its req_a, req_b and req_redux into mult_a, mult_b and mult_redux.
  - Set rr_ptr to winner+1 mod N_REQ.
  - Go to LOAD.
- LOAD: mult_rst=1 for one more cycle to flush the multiplier with the new operands. Go to RUN.
- RUN: mult_rst=0. Operands hold stable. When mult_valid=1, capture mult_u into result and go to DONE.
- DONE: pulse done[winner]. mult_rst=1. Go to IDLE.
- Requester handshake:
  - Operands are sampled only in the gnt cycle; the requester may change them afterwards.
  - A requester holds req until it sees gnt.
  - If req drops after gnt, the transaction still completes and done still pulses.
  - If req is still high in the cycle after done, that is a new request.
- Fairness: the last winner has lowest priority. With all req bits high, grants rotate 0,1,2,3,0,…
- req changes outside IDLE are ignored. No queuing.
- result holds its value until the next DONE capture.
- Reset values: gnt=0, done=0, err=0, busy=0, result=0, mult_rst=1, mult_redux=0, mult_a=0, mult_b=0, rr_ptr=0, state=IDLE.
- Reset mid-transaction aborts immediately. No done is issued, and mult_rst returns to 1.

## Timing
- Request seen in IDLE at cycle t. gnt at t (registered, visible in t+1).
- LOAD at t+1. RUN from t+2.
- mult_valid observed at cycle v. DONE at v+1, with done and result visible at v+2.
- Back-to-back: the next gnt can occur in the cycle after DONE, so there are 4 cycles of overhead plus the multiplier latency.
- mult_valid outside RUN is ignored.

## Configuration
- MULT_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in RUN.
  - On reaching TIMEOUT_CYCLES without mult_valid, go to DONE with err=1 and result=0.
  - The counter clears on entering RUN.
  - If mult_valid and the timeout coincide, mult_valid wins and err=0.
- MULT_ARB_TIMEOUT_EN undefined: no counter, err is tied to 0, and RUN waits indefinitely.

## Structure
- Package mult_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3)
  - the field constant P
  - the default TIMEOUT_CYCLES
- One sub-module, rr_arbiter (parameter N_REQ). It is combinational: inputs req and rr_ptr; outputs one-hot winner, winner index and any_req.
- The top instantiates rr_arbiter and connects to an external multiplier. The multiplier is not instantiated inside.

## Test plan
- Single request: req=4'b0001, a=2, b=3, redux=1 → gnt[0] pulse, done[0] pulse, result=6, err=0.
- Reduction check: a=b=P−1, redux=1 → result=1. Same operands with redux=0 → result=(P−1)^2 (full 510-bit value).
- Round-robin: req=4'b1111 held for four transactions, each requester using a distinct a → grants in order 0,1,2,3. Each done/result matches that requester's operands.
- req dropped the cycle after gnt → transaction completes, done pulses, no second grant.
- rst_n asserted in RUN → all outputs return to reset values within the same cycle, mult_rst=1, no done. After release, a new req=4'b0100 is granted first, since rr_ptr=0 and only requester 2 is requesting.
- MULT_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and mult_valid never asserted → done with err=1 and result=0, 16 cycles after entering RUN.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the field-multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned FIELD_W = 256;

  // p = 2^255 - 19
  localparam logic [FIELD_W-1:0] P =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner_c,
  output logic [IDX_W-1:0] winner_idx_c,
  output logic             any_req_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner_c     = '0;
    winner_idx_c = '0;
    any_req_c    = 1'b0;
    cand         = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % N_REQ);
      if (!any_req_c && req[cand]) begin
        any_req_c      = 1'b1;
        winner_idx_c   = cand;
        winner_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external field multiplier between N_REQ requesters (grant, run, done).
// Optional watchdog abort in RUN when MULT_ARB_TIMEOUT_EN is defined.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned BIT_LENGTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_redux,
  input  logic [N_REQ*BIT_LENGTH-1:0] req_a,
  input  logic [N_REQ*BIT_LENGTH-1:0] req_b,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic                        err,
  output logic [2*BIT_LENGTH-1:0]     result,
  output logic                        busy,
  output logic                        mult_rst,
  output logic                        mult_redux,
  output logic [BIT_LENGTH-1:0]       mult_a,
  output logic [BIT_LENGTH-1:0]       mult_b,
  input  logic [2*BIT_LENGTH-1:0]     mult_u,
  input  logic                        mult_valid
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mult_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_t                    state, state_nxt;
  logic [N_REQ-1:0]          gnt_nxt, done_nxt, owner, owner_nxt;
  logic [2*BIT_LENGTH-1:0]   result_nxt;
  logic                      busy_nxt, mult_rst_nxt, mult_redux_nxt;
  logic [BIT_LENGTH-1:0]     mult_a_nxt, mult_b_nxt;
  logic [IDX_W-1:0]          rr_ptr, rr_ptr_nxt;

  logic [N_REQ-1:0]          winner_c;
  logic [IDX_W-1:0]          winner_idx_c;
  logic                      any_req_c;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             abort, abort_nxt, err_nxt;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req          (req),
    .rr_ptr       (rr_ptr),
    .winner_c     (winner_c),
    .winner_idx_c (winner_idx_c),
    .any_req_c    (any_req_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      done       <= '0;
      owner      <= '0;
      result     <= '0;
      busy       <= 1'b0;
      mult_rst   <= 1'b1;
      mult_redux <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      owner      <= owner_nxt;
      result     <= result_nxt;
      busy       <= busy_nxt;
      mult_rst   <= mult_rst_nxt;
      mult_redux <= mult_redux_nxt;
      mult_a     <= mult_a_nxt;
      mult_b     <= mult_b_nxt;
      rr_ptr     <= rr_ptr_nxt;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      abort <= 1'b0;
      err   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      abort <= abort_nxt;
      err   <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = '0;
    done_nxt       = '0;
    owner_nxt      = owner;
    result_nxt     = result;
    mult_redux_nxt = mult_redux;
    mult_a_nxt     = mult_a;
    mult_b_nxt     = mult_b;
    rr_ptr_nxt     = rr_ptr;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_nxt        = '0;
    abort_nxt      = abort;
    err_nxt        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (any_req_c) begin
          state_nxt      = LOAD;
          gnt_nxt        = winner_c;
          owner_nxt      = winner_c;
          mult_a_nxt     = req_a[winner_idx_c*BIT_LENGTH +: BIT_LENGTH];
          mult_b_nxt     = req_b[winner_idx_c*BIT_LENGTH +: BIT_LENGTH];
          mult_redux_nxt = req_redux[winner_idx_c];
          rr_ptr_nxt     = (winner_idx_c == IDX_W'(N_REQ - 1)) ? '0
                                                               : winner_idx_c + IDX_W'(1);
`ifdef MULT_ARB_TIMEOUT_EN
          abort_nxt      = 1'b0;
`endif
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (mult_valid) begin
          result_nxt = mult_u;
          state_nxt  = DONE;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        // A coincident mult_valid takes priority over the watchdog
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_nxt = '0;
          abort_nxt  = 1'b1;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        done_nxt  = owner;
        state_nxt = IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
        err_nxt   = abort;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt     = (state_nxt != IDLE);
    mult_rst_nxt = (state_nxt != RUN);
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-timeline model checked every cycle plus literal checks.
module tb_mult_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 256;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 64;
`endif
  localparam logic [W-1:0] P_REF = (256'd1 << 255) - 256'd19;

  logic             clk, rst_n;
  logic [N-1:0]     req, req_redux;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     gnt, done;
  logic             err, busy, mult_rst, mult_redux, mult_valid;
  logic [2*W-1:0]   result, mult_u;
  logic [W-1:0]     mult_a, mult_b;

  int n_vec = 0;
  int n_miss = 0;

  mult_arbiter #(.N_REQ(N), .BIT_LENGTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_redux(req_redux), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy), .mult_rst(mult_rst),
    .mult_redux(mult_redux), .mult_a(mult_a), .mult_b(mult_b), .mult_u(mult_u),
    .mult_valid(mult_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic r);
    logic [2*W-1:0] full;
    full = (2*W)'(a) * (2*W)'(b);
    return r ? full % (2*W)'(P_REF) : full;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // External multiplier stand-in: fixed latency after mult_rst drops
  int  mcnt = 0;
  int  mul_lat = 3;
  bit  mul_en = 1'b1;
  bit  spur = 1'b0;
  initial begin mult_valid = 1'b0; mult_u = '0; end
  always @(posedge clk) begin
    if (mult_rst) begin
      mcnt       <= 0;
      mult_valid <= spur;
      if (spur) mult_u <= '1;
    end else begin
      mcnt       <= mcnt + 1;
      mult_valid <= mul_en && (mcnt + 1 == mul_lat);
      mult_u     <= ref_mul(mult_a, mult_b, mult_redux);
    end
  end

  // Reference model: expected outputs for the next cycle, built from the transaction timeline
  bit             m_active, m_donecyc, m_err, m_found;
  int             m_age, m_ptr, m_owner, m_sel;
  logic [W-1:0]   m_a, m_b;
  logic           m_r;
  logic [N-1:0]   e_gnt, e_done;
  logic           e_err, e_busy, e_mrst, e_redux;
  logic [W-1:0]   e_a, e_b;
  logic [2*W-1:0] e_result;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_donecyc = 0; m_err = 0; m_ptr = 0; m_age = 0; m_owner = 0;
      e_gnt = '0; e_done = '0; e_err = 0; e_busy = 0; e_mrst = 1; e_redux = 0;
      e_a = '0; e_b = '0; e_result = '0;
    end
    check("gnt", gnt, e_gnt);
    check("done", done, e_done);
    check("err", err, e_err);
    check("busy", busy, e_busy);
    check("mult_rst", mult_rst, e_mrst);
    check("mult_redux", mult_redux, e_redux);
    check("mult_a", mult_a, e_a);
    check("mult_b", mult_b, e_b);
    check("result", result, e_result);
    if (rst_n) begin
      e_gnt = '0; e_done = '0; e_err = 0;
      if (!m_active) begin
        e_busy = 0; e_mrst = 1;
        m_found = 0; m_sel = 0;
        for (int k = 0; k < N; k++)
          if (!m_found && req[(m_ptr + k) % N]) begin m_found = 1; m_sel = (m_ptr + k) % N; end
        if (m_found) begin
          m_owner = m_sel; m_ptr = (m_sel + 1) % N;
          m_a = req_a[m_sel*W +: W]; m_b = req_b[m_sel*W +: W]; m_r = req_redux[m_sel];
          e_gnt[m_sel] = 1'b1; e_a = m_a; e_b = m_b; e_redux = m_r;
          e_busy = 1; e_mrst = 1;
          m_active = 1; m_age = 0; m_donecyc = 0; m_err = 0;
        end
      end else begin
        m_age++;
        if (m_donecyc) begin
          e_done[m_owner] = 1'b1; e_err = m_err; e_busy = 0; e_mrst = 1; m_active = 0;
        end else if (m_age == 1) begin
          e_busy = 1; e_mrst = 0;
        end else if (mult_valid) begin
          e_result = ref_mul(m_a, m_b, m_r); e_busy = 1; e_mrst = 1; m_donecyc = 1;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (m_age - 2 == TO - 1) begin
          e_result = '0; m_err = 1; e_busy = 1; e_mrst = 1; m_donecyc = 1;
        end
`endif
        else begin
          e_busy = 1; e_mrst = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_redux[i] = r;
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int n = 0; n < 50 && idx < 0; n++) begin
      tick();
      for (int k = 0; k < N; k++) if (gnt[k]) idx = k;
    end
    if (idx < 0) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      seen = (done != '0);
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  int g;
  logic [2*W-1:0] exp_rr [4];

  initial begin
    rst_n = 1'b0; req = '0; req_redux = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_mult_rst", mult_rst, 1);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request, reduced product 2*3
    set_op(0, 256'd2, 256'd3, 1'b1); req = 4'b0001;
    wait_gnt(g); req = '0;
    check("single_gnt_idx", g, 0);
    wait_done();
    check("single_done", done, 4'b0001);
    check("single_result", result, 512'd6);
    check("single_err", err, 0);

    // (p-1)^2 mod p == 1
    set_op(1, P_REF - 256'd1, P_REF - 256'd1, 1'b1); req = 4'b0010;
    wait_gnt(g); req = '0;
    wait_done();
    check("redux_result", result, 512'd1);

    // (p-1)^2 full = 2^510 - 5*2^258 + 400
    set_op(2, P_REF - 256'd1, P_REF - 256'd1, 1'b0); req = 4'b0100;
    wait_gnt(g); req = '0;
    wait_done();
    check("full_result", result, (512'd1 << 510) - (512'd5 << 258) + 512'd400);

    // Requester 3 drops req after gnt: completes once, no re-grant
    set_op(3, 256'd11, 256'd13, 1'b0); req = 4'b1000;
    wait_gnt(g); req = '0;
    check("drop_gnt_idx", g, 3);
    wait_done();
    check("drop_done", done, 4'b1000);
    check("drop_result", result, 512'd143);
    for (int n = 0; n < 8; n++) begin
      tick();
      check("drop_no_regrant", gnt, 0);
    end

    // Round robin with all requests held
    exp_rr = '{512'd200, 512'd231, 512'd264, 512'd299};
    for (int i = 0; i < N; i++) set_op(i, W'(10 + i), W'(20 + i), 1'b1);
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      mul_lat = 1 + 2 * i;
      wait_gnt(g);
      check("rr_order", g, i);
      wait_done();
      if (i == N - 1) req = '0;
      check("rr_done", done, 4'b0001 << i);
      check("rr_result", result, exp_rr[i]);
    end

    // mult_valid while idle must be ignored
    mul_lat = 3;
    spur = 1'b1; repeat (3) tick(); spur = 1'b0;
    repeat (3) tick();
    check("spur_busy", busy, 0);
    check("spur_result", result, 512'd299);

    // Reset during RUN aborts without done
    mul_lat = 40;
    set_op(1, 256'd7, 256'd8, 1'b0); req = 4'b0010;
    wait_gnt(g); req = '0;
    repeat (4) tick();
    check("in_run", mult_rst, 0);
    rst_n = 1'b0; #1;
    check("arst_busy", busy, 0);
    check("arst_mult_rst", mult_rst, 1);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_mult_a", mult_a, 0);
    repeat (2) tick();
    rst_n = 1'b1; mul_lat = 3;
    set_op(2, 256'd5, 256'd9, 1'b0); req = 4'b0100;
    wait_gnt(g); req = '0;
    check("post_rst_gnt", g, 2);
    wait_done();
    check("post_rst_result", result, 512'd45);

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: DONE 16 cycles after entering RUN, err set, result cleared
    mul_en = 1'b0;
    set_op(0, 256'd3, 256'd3, 1'b0); req = 4'b0001;
    wait_gnt(g); req = '0;
    tick();
    begin
      int n = 0;
      tick();
      while (!(busy && mult_rst) && n < 100) begin tick(); n++; end
      check("timeout_cycles", n, 16);
    end
    tick();
    check("timeout_done", done, 4'b0001);
    check("timeout_err", err, 1);
    check("timeout_result", result, 0);
    mul_en = 1'b1;
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
